// File: rtl/mult_arbiter_4.sv
// ============================================================================
// Module      : mult_arbiter_4
// Description : Round-robin arbiter sharing one pipelined field multiplier
//               among four requesters, with in-order tagged result return.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mult_arbiter_4 #(
    parameter int MULT_LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [3:0]     req_valid,
    input  logic [1023:0]  req_a,
    input  logic [1023:0]  req_b,
    output logic [3:0]     req_ready,
    output logic [255:0]   mult_in_0,
    output logic [255:0]   mult_in_1,
    input  logic [254:0]   mult_out,
    output logic [3:0]     rsp_valid,
    output logic [254:0]   rsp_data,
    output logic [3:0]     inflight,
    output logic           idle
);

    localparam int DEPTH = MULT_LATENCY + 1;

    logic [1:0]            ptr_q;
    logic [255:0]          mult_in_0_q;
    logic [255:0]          mult_in_1_q;
    logic [DEPTH-1:0]      tag_v_q;
    logic [DEPTH-1:0][1:0] tag_id_q;
    logic [3:0]            rsp_valid_q;
    logic [254:0]          rsp_data_q;
    logic [3:0]            inflight_q;
    logic [3:0]            inflight_d;

    logic [3:0]            w_grant;
    logic [1:0]            w_gnt_idx;
    logic [1:0]            w_cand;
    logic                  w_found;
    logic                  w_hs;
    logic                  w_retire;

    // Search starts at the pointer and wraps naturally through the 2-bit add.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = ptr_q;
        w_cand    = '0;
        w_found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_cand = ptr_q + 2'(k);
            if (!w_found && en && !rst && req_valid[w_cand]) begin
                w_found            = 1'b1;
                w_grant[w_cand]    = 1'b1;
                w_gnt_idx          = w_cand;
            end
        end
    end

    assign w_hs     = |w_grant;
    assign w_retire = tag_v_q[DEPTH-1];

    always_comb begin
        inflight_d = inflight_q;
        if (w_hs && !w_retire) begin
            inflight_d = inflight_q + 4'd1;
        end else if (!w_hs && w_retire) begin
            inflight_d = inflight_q - 4'd1;
        end
    end

    // The tag leaving the last stage lines up with mult_out for that issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            mult_in_0_q <= '0;
            mult_in_1_q <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            if (w_hs) begin
                ptr_q       <= w_gnt_idx + 2'd1;
                mult_in_0_q <= req_a[{w_gnt_idx, 8'd0} +: 256];
                mult_in_1_q <= req_b[{w_gnt_idx, 8'd0} +: 256];
            end
            tag_v_q     <= {tag_v_q[DEPTH-2:0], w_hs};
            tag_id_q    <= {tag_id_q[DEPTH-2:0], w_gnt_idx};
            rsp_valid_q <= w_retire ? (4'd1 << tag_id_q[DEPTH-1]) : 4'd0;
            if (w_retire) begin
                rsp_data_q <= mult_out;
            end
            inflight_q  <= inflight_d;
        end
    end

    assign req_ready = w_grant;
    assign mult_in_0 = mult_in_0_q;
    assign mult_in_1 = mult_in_1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign inflight  = inflight_q;
    assign idle      = (inflight_q == 4'd0);

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter_4.sv
// ============================================================================
// Module      : tb_mult_arbiter_4
// Description : Randomized self-checking bench with a queue-based reference
//               model of grants, result timing and occupancy.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mult_arbiter_4;

    localparam int L = 4;
    localparam logic [511:0] P = (512'd1 << 255) - 512'd19;

    logic           clk;
    logic           rst;
    logic           en;
    logic [3:0]     req_valid;
    logic [1023:0]  req_a;
    logic [1023:0]  req_b;
    logic [3:0]     req_ready;
    logic [255:0]   mult_in_0;
    logic [255:0]   mult_in_1;
    logic [254:0]   mult_out;
    logic [3:0]     rsp_valid;
    logic [254:0]   rsp_data;
    logic [3:0]     inflight;
    logic           idle;

    mult_arbiter_4 #(.MULT_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mult_in_0(mult_in_0), .mult_in_1(mult_in_1), .mult_out(mult_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inflight(inflight), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [254:0] fmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] pr;
        pr = 512'(a) * 512'(b);
        return 255'(pr % P);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // External multiplier: L-cycle pipeline fed from the registered operands.
    logic [254:0] mpipe [0:L-1];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mult_in_0, mult_in_1);
        for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mult_out = mpipe[L-1];

    // Reference model: expected results queued with the cycle they must strobe.
    typedef struct {
        int           due;
        int           id;
        logic [254:0] data;
    } exp_t;

    exp_t         q[$];
    int           cyc;
    int           ptr;
    logic [254:0] m_rsp_data;
    logic [255:0] m_in0, m_in1;
    int           n_pass, n_total;

    function automatic int grant_idx();
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (ptr + k) % 4;
            if (!rst && en && req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = grant_idx();
        return (g < 0) ? 4'd0 : 4'(1 << g);
    endfunction

    function automatic logic [3:0] exp_rsp();
        if (q.size() > 0 && q[0].due == cyc) return 4'(1 << q[0].id);
        return 4'd0;
    endfunction

    function automatic logic [254:0] exp_data();
        if (q.size() > 0 && q[0].due == cyc) return q[0].data;
        return m_rsp_data;
    endfunction

    function automatic int exp_inflight();
        int n;
        n = 0;
        foreach (q[i]) if (q[i].due > cyc) n++;
        return n;
    endfunction

    task automatic tick();
        int g;
        logic [255:0] a, b;
        g = grant_idx();
        if (g >= 0) begin
            a = req_a[256*g +: 256];
            b = req_b[256*g +: 256];
        end
        @(posedge clk);
        if (q.size() > 0 && q[0].due == cyc) begin
            m_rsp_data = q[0].data;
            void'(q.pop_front());
        end
        if (rst) begin
            q.delete();
            ptr = 0;
            m_rsp_data = '0;
            m_in0 = '0;
            m_in1 = '0;
        end else if (g >= 0) begin
            q.push_back('{due: cyc + 2 + L, id: g, data: fmul(a, b)});
            ptr = (g + 1) % 4;
            m_in0 = a;
            m_in1 = b;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req_valid = 4'hF;
        req_a = {rnd256(), rnd256(), rnd256(), rnd256()};
        req_b = {rnd256(), rnd256(), rnd256(), rnd256()};
        @(negedge clk);
        n_total++;
        if (req_ready !== 4'd0) $display("FAIL reset_ready got %b exp 0000", req_ready); else n_pass++;
        tick();
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        n_total++;
        if (mult_in_0 !== '0 || mult_in_1 !== '0) $display("FAIL reset_mult_in got %h/%h exp 0", mult_in_0, mult_in_1); else n_pass++;
        n_total++;
        if (rsp_valid !== 4'd0 || rsp_data !== '0) $display("FAIL reset_rsp got %b/%h exp 0", rsp_valid, rsp_data); else n_pass++;
        n_total++;
        if (inflight !== 4'd0 || idle !== 1'b1) $display("FAIL reset_inflight got %0d idle %b exp 0 idle 1", inflight, idle); else n_pass++;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_a = '0; req_b = '0;
        req_a[255:0] = 256'd3; req_b[255:0] = 256'd5;
        for (int c = 0; c <= 7; c++) begin
            req_valid = (c == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (c == 0) begin
                n_total++;
                if (req_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", req_ready); else n_pass++;
            end
            if (c == 1) begin
                n_total++;
                if (mult_in_0 !== 256'd3 || mult_in_1 !== 256'd5) $display("FAIL single_mult_in got %0d/%0d exp 3/5", mult_in_0, mult_in_1); else n_pass++;
            end
            n_total++;
            if (rsp_valid !== ((c == 6) ? 4'b0001 : 4'b0000)) $display("FAIL single_rsp_valid c=%0d got %b", c, rsp_valid); else n_pass++;
            if (c == 6) begin
                n_total++;
                if (rsp_data !== 255'd15) $display("FAIL single_rsp_data got %0d exp 15", rsp_data); else n_pass++;
            end
            if (c == 7) begin
                n_total++;
                if (idle !== 1'b1 || inflight !== 4'd0) $display("FAIL single_idle got %b/%0d exp 1/0", idle, inflight); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int c = 0; c < 15; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            req_a = {rnd256(), rnd256(), rnd256(), rnd256()};
            req_b = {rnd256(), rnd256(), rnd256(), rnd256()};
            @(negedge clk);
            if (c < 8) begin
                n_total++;
                if (req_ready !== 4'(1 << (c % 4))) $display("FAIL fair_grant c=%0d got %b exp %b", c, req_ready, 4'(1 << (c % 4))); else n_pass++;
            end
            n_total++;
            if (rsp_valid !== ((c >= 6 && c < 14) ? 4'(1 << ((c - 6) % 4)) : 4'd0))
                $display("FAIL fair_rsp c=%0d got %b", c, rsp_valid);
            else n_pass++;
            n_total++;
            if (rsp_data !== exp_data()) $display("FAIL fair_data c=%0d got %h exp %h", c, rsp_data, exp_data()); else n_pass++;
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        req_a = '0; req_b = '0;
        for (int c = 0; c < 24; c++) begin
            req_valid = (c < 16) ? 4'b0100 : 4'b0000;
            req_a[512 +: 256] = 256'(c);
            req_b[512 +: 256] = 256'd2;
            @(negedge clk);
            if (c >= 5 && c <= 16) begin
                n_total++;
                if (inflight !== 4'd5) $display("FAIL sat_inflight c=%0d got %0d exp 5", c, inflight); else n_pass++;
            end
            if (c >= 6 && c < 22) begin
                n_total++;
                if (rsp_valid !== 4'b0100 || rsp_data !== 255'(2 * (c - 6)))
                    $display("FAIL sat_rsp c=%0d got %b/%0d exp 0100/%0d", c, rsp_valid, rsp_data, 2 * (c - 6));
                else n_pass++;
            end
            n_total++;
            if (inflight !== 4'(exp_inflight())) $display("FAIL sat_model_inflight c=%0d got %0d exp %0d", c, inflight, exp_inflight()); else n_pass++;
            tick();
        end
    endtask

    task automatic test_enable();
        do_reset();
        req_a = {rnd256(), rnd256(), rnd256(), rnd256()};
        req_b = {rnd256(), rnd256(), rnd256(), rnd256()};
        for (int c = 0; c <= 11; c++) begin
            en = (c >= 4);
            req_valid = (c <= 4) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            if (c <= 4) begin
                n_total++;
                if (req_ready !== ((c == 4) ? 4'b0010 : 4'b0000)) $display("FAIL en_ready c=%0d got %b", c, req_ready); else n_pass++;
            end
            n_total++;
            if (rsp_valid !== ((c == 10) ? 4'b0010 : 4'b0000)) $display("FAIL en_rsp c=%0d got %b", c, rsp_valid); else n_pass++;
            tick();
        end
        en = 1'b1;
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            rst = (c == 3);
            req_valid = (c <= 3) ? 4'(1 << $urandom_range(0, 3)) | 4'($urandom) : 4'd0;
            req_a = {rnd256(), rnd256(), rnd256(), rnd256()};
            req_b = {rnd256(), rnd256(), rnd256(), rnd256()};
            @(negedge clk);
            if (c == 3) begin
                n_total++;
                if (req_ready !== 4'd0) $display("FAIL flush_ready_in_rst got %b exp 0000", req_ready); else n_pass++;
            end
            n_total++;
            if (rsp_valid !== 4'd0) $display("FAIL flush_rsp c=%0d got %b exp 0000", c, rsp_valid); else n_pass++;
            if (c >= 4) begin
                n_total++;
                if (inflight !== 4'd0 || idle !== 1'b1) $display("FAIL flush_inflight c=%0d got %0d exp 0", c, inflight); else n_pass++;
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            en = ($urandom_range(0, 7) != 0);
            req_valid = (c < 390) ? 4'($urandom) : 4'd0;
            req_a = {rnd256(), rnd256(), rnd256(), rnd256()};
            req_b = {rnd256(), rnd256(), rnd256(), rnd256()};
            @(negedge clk);
            n_total++;
            if (req_ready !== exp_ready()) $display("FAIL rnd_ready c=%0d got %b exp %b", c, req_ready, exp_ready()); else n_pass++;
            n_total++;
            if (rsp_valid !== exp_rsp()) $display("FAIL rnd_rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_rsp()); else n_pass++;
            n_total++;
            if (rsp_data !== exp_data()) $display("FAIL rnd_rsp_data c=%0d got %h exp %h", c, rsp_data, exp_data()); else n_pass++;
            n_total++;
            if (inflight !== 4'(exp_inflight()) || idle !== (exp_inflight() == 0))
                $display("FAIL rnd_inflight c=%0d got %0d/%b exp %0d", c, inflight, idle, exp_inflight());
            else n_pass++;
            n_total++;
            if (mult_in_0 !== m_in0 || mult_in_1 !== m_in1) $display("FAIL rnd_mult_in c=%0d got %h/%h exp %h/%h", c, mult_in_0, mult_in_1, m_in0, m_in1); else n_pass++;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0; cyc = 0; ptr = 0;
        m_rsp_data = '0; m_in0 = '0; m_in1 = '0;
        rst = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        test_reset();
        test_single();
        test_fairness();
        test_saturation();
        test_enable();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
